sm3_msg_expand: RTL
===================

# sm3_msg_expand

SM3 message-expansion stage sitting directly downstream of the SM3 padding unit and upstream of the compression-round datapath. Accepts the padder's 1024-bit result plus its `double` flag, then streams the 64 round-word pairs (W_j, W'_j) for one or two 512-bit blocks to the compressor under a valid/ready handshake. Uses a 16-word sliding window, so only one new expanded word is computed per accepted round.

## Interface
- No parameters; word width 32, rounds 64, block 512 are fixed constants.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- din  in  1024  padded message; block 0 = din[1023:512], block 1 = din[511:0]
- din_double  in  1  block 1 present; sampled with din
- din_valid  in  1  single-cycle strobe; captures din/din_double
- busy  out  1  expansion in progress; din_valid ignored while high
- w_out  out  32  W_j for current round
- wp_out  out  32  W'_j = W_j ^ W_{j+4}
- w_idx  out  6  round index j
- w_blk  out  1  block being expanded (0 or 1)
- w_valid  out  1  w_out/wp_out/w_idx/w_blk valid
- w_ready  in  1  consumer accepts the current round
- blk_last  out  1  current block is the final block of the message
- done  out  1  one-cycle pulse after the final round of the final block is accepted

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: on din_valid, register din and din_double, go to LOAD, busy=1.
- LOAD: window W[0..15] <= selected block, big-endian words (W0 = block[511:480]); idx <= 0; go to RUN.
- RUN: w_valid=1; w_out=W[0]; wp_out=W[0]^W[4]. On w_valid&&w_ready: window shifts down one word; W[15] <= P1(W[0]^W[7]^ROTL(W[13],15)) ^ ROTL(W[3],7) ^ W[10]; idx++.
- P1(x) = x ^ ROTL(x,15) ^ ROTL(x,23). All arithmetic is XOR/rotate, 32-bit, no carries.
- Accept at idx 63: if blk 0 and din_double, set blk to 1 and go to LOAD with din[511:0]; otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- blk_last = (w_blk==1) || !din_double_reg.
- w_ready low: all outputs hold and the window is frozen.
- din_valid while busy: dropped, with no effect on the registered data.
- Expanded words W64..W67 are never emitted; no computation beyond the idx 63 shift is required.

## Timing
- Reset value of every output and state register is 0; state is IDLE.
- din_valid in cycle N puts the FSM in LOAD at N+1. The first w_valid, carrying idx 0, appears at N+2.
- With w_ready tied high:
  - single block: idx 63 is shown at N+65; done at N+66; busy falls at N+66.
  - double block: LOAD occupies N+66; block 1 idx 0 appears at N+67; done at N+131.
- There is exactly one LOAD bubble (w_valid=0) between the two blocks.
- done and din_valid in the same cycle: din_valid is ignored. A new message is accepted from the following IDLE cycle.
- rstn asserted mid-stream clears everything immediately. There is no partial flush and no done pulse.

## Configuration
- SM3_EXPAND_WPRIME_EN defined: wp_out is computed as specified.
- Not defined: wp_out is driven constant 0, with the port retained; the compressor derives W'_j itself. The window and all timing are unchanged.

## Structure
- Shared package `sm3_pkg` holds:
  - the constants SM3_WORD_W=32, SM3_ROUNDS=64, SM3_BLOCK_W=512;
  - the state enum;
  - the rotl32 and p1 functions, which the compressor also uses (P0 lives there too).
- One natural sub-module, `sm3_w_window`: the 16x32 shift window plus the next-word combinational logic, with load/shift enables. The FSM and handshake stay in the top level.

## Test plan
- Padded "abc" (block 0 = 0x61626380, zeros, last word 0x00000018; din_double=0), w_ready=1 -> idx0 w_out=0x61626380, wp_out=0x61626380; idx16 w_out=0x9092e200; idx17 0x00000000; idx18 0x000c0606; done at N+66, blk_last=1 throughout.
- Same as "abc" but din_double=1, block 1 all zeros except last word 0x00000200 -> 64 rounds with w_blk=0, one bubble, then 64 rounds with w_blk=1; block 1 idx15 w_out=0x00000200 and idx0 w_out=0; done at N+131.
- "abc" stream with w_ready toggled pseudo-randomly (e.g. 1 cycle in 3 low) -> identical word sequence to the w_ready=1 run; outputs stable while stalled.
- Second din_valid issued at idx 10, then a legal one issued the cycle after done -> first is ignored and the stream stays unchanged; second starts a fresh expansion from idx 0.
- rstn pulsed low at idx 30 -> all outputs 0 asynchronously, no done pulse; a subsequent "abc" run matches the golden values.
- Build without SM3_EXPAND_WPRIME_EN -> wp_out == 0 at all rounds; w_out sequence and timing identical to the enabled build.

Source files
------------

// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 constants, expansion FSM states and XOR/rotate word functions
package sm3_pkg;
  localparam int SM3_WORD_W = 32;
  localparam int SM3_ROUNDS = 64;
  localparam int SM3_BLOCK_W = 512;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl32(x, 9) ^ rotl32(x, 17);
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl32(x, 15) ^ rotl32(x, 23);
  endfunction
endpackage

// File: rtl/sm3_w_window.sv
// sm3_w_window: 16x32 sliding expansion window; W' = W0^W4 only when SM3_EXPAND_WPRIME_EN
module sm3_w_window
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] blk,
  output logic [31:0]  w0,
  output logic [31:0]  wp
);
  logic [31:0] w [16];
  logic [31:0] nxt;
  assign nxt = p1(w[0] ^ w[7] ^ rotl32(w[13], 15)) ^ rotl32(w[3], 7) ^ w[10];
  assign w0 = w[0];
`ifdef SM3_EXPAND_WPRIME_EN
  assign wp = w[0] ^ w[4];
`else
  assign wp = '0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w[i] <= blk[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= nxt;
    end
  end
endmodule

// File: rtl/sm3_msg_expand.sv
// sm3_msg_expand: streams SM3 (W_j, W'_j) for one or two padded blocks; W' enabled by SM3_EXPAND_WPRIME_EN
module sm3_msg_expand
  import sm3_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic [1023:0] din,
  input  logic          din_double,
  input  logic          din_valid,
  output logic          busy,
  output logic [31:0]   w_out,
  output logic [31:0]   wp_out,
  output logic [5:0]    w_idx,
  output logic          w_blk,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          blk_last,
  output logic          done
);
  state_t state, state_nxt;
  logic [1023:0] din_r;
  logic dbl_r, acc, last_rnd, more;
  assign acc = w_valid && w_ready;
  assign last_rnd = acc && (w_idx == 6'd63);
  assign more = !w_blk && dbl_r;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    busy = 1'b0;
    w_valid = 1'b0;
    done = 1'b0;
    blk_last = 1'b0;
    state_nxt = (state == IDLE) ? (din_valid ? LOAD : IDLE) :
                (state == LOAD) ? RUN :
                (state == RUN)  ? (!last_rnd ? RUN : more ? LOAD : DONE) : IDLE;
    busy = (state == LOAD) || (state == RUN);
    w_valid = (state == RUN);
    done = (state == DONE);
    blk_last = (state != IDLE) && (w_blk || !dbl_r);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_r <= '0;
      dbl_r <= 1'b0;
      w_idx <= '0;
      w_blk <= 1'b0;
    end else begin
      if (state == IDLE && din_valid) begin
        din_r <= din;
        dbl_r <= din_double;
        w_blk <= 1'b0;
      end
      if (state == LOAD) w_idx <= '0;
      else if (acc) w_idx <= w_idx + 6'd1;
      if (last_rnd && more) w_blk <= 1'b1;
    end
  end
  sm3_w_window u_win (
    .clk(clk),
    .rstn(rstn),
    .load(state == LOAD),
    .shift(acc),
    .blk(w_blk ? din_r[511:0] : din_r[1023:512]),
    .w0(w_out),
    .wp(wp_out)
  );
endmodule
